saturn_instr_decoder: RTL and testbench
=======================================

SATURN_INSTR_DECODER -- requirements
Module: saturn_instr_decoder

Interface
REQ-001 Parameter ADDR_NIBBLES, default 5: address field width in nibbles; address/offset outputs are 4*ADDR_NIBBLES bits wide, and the value SHALL be at least 4.
REQ-002 Parameter EN_LONG, default 1: when 1, the 8C/8D/8E/8F long-jump group SHALL be decoded; when 0, a first nibble 8 SHALL be illegal.
REQ-003 i_clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 i_reset  input  1  asynchronous, active-low reset.
REQ-005 i_en_dec  input  1  nibble strobe; i_nibble is consumed only on edges where it is 1.
REQ-006 i_nibble  input  4  instruction nibble, fetch order.
REQ-007 i_flush  input  1  abort the partial instruction (branch taken, refetch).
REQ-008 o_ins_valid  output  1  one-cycle pulse: decode result valid.
REQ-009 o_ins_class  output  4  0 NONE, 1 RTN, 2 SETHEX, 3 SETDEC, 4 GOC, 5 GONC, 6 GOTO, 7 GOSUB, 8 GOLONG, 9 GOVLNG, A GOSUBL, B GOSBVL, F ILLEGAL.
REQ-010 o_set_xm, o_set_carry, o_carry_val  output  1 each  RTN-family modifiers.
REQ-011 o_jump_rel  output  1  1 when o_jump_field is a signed relative offset; 0 when it is absolute.
REQ-012 o_jump_field  output  4*ADDR_NIBBLES  assembled jump field.
REQ-013 o_busy  output  1  a partial instruction is held.
REQ-014 o_instr_ctr  output  32  count of completed non-illegal instructions.

Function
REQ-015 State machine states: START, B0 (after 0), B8 (after 8), FIELD (collecting jump nibbles); the machine SHALL change state only on an edge with i_en_dec=1 or i_flush=1.
REQ-016 START transitions: nibble 0 -> B0; 4/5 -> FIELD with length 2; 6/7 -> FIELD with length 3; 8 -> B8 when EN_LONG=1; any other nibble -> ILLEGAL completion, staying in START.
REQ-017 B0 transitions: nibble 0/1/2/3 -> RTN completion with set_xm=(n==0), set_carry=(n==2|n==3), carry_val=(n==2); nibble 4 -> SETHEX; nibble 5 -> SETDEC; any other nibble -> ILLEGAL; every case returns to START.
REQ-018 B8 transitions: C -> FIELD length 4 (GOLONG); E -> FIELD length 4 (GOSUBL); D -> FIELD length ADDR_NIBBLES (GOVLNG); F -> FIELD length ADDR_NIBBLES (GOSBVL); any other nibble -> ILLEGAL and return to START.
REQ-019 FIELD SHALL assemble nibbles least-significant first: nibble k lands in bits [4k+3:4k].
REQ-020 On acceptance of the final field nibble, the machine SHALL complete the instruction and return to START.
REQ-021 Relative classes (GOC, GONC, GOTO, GOSUB, GOLONG, GOSUBL) SHALL sign-extend the field to full width and drive o_jump_rel=1.
REQ-022 Absolute classes (GOVLNG, GOSBVL) SHALL zero-extend the field and drive o_jump_rel=0.
REQ-023 Completion SHALL be registered on the edge that accepts the final nibble: o_ins_valid=1 for exactly the next cycle, with the class, modifiers and field stable during that cycle.
REQ-024 Latency SHALL be zero extra cycles after the final nibble.
REQ-025 When o_ins_valid=0: o_ins_class=0, o_set_xm/o_set_carry/o_carry_val=0, o_jump_rel=0, and o_jump_field holds its last value.
REQ-026 ILLEGAL completion SHALL drive class F and leave o_instr_ctr unchanged.
REQ-027 Every other completion SHALL increment o_instr_ctr by 1, wrapping from FFFFFFFF to 0.
REQ-028 o_busy SHALL be 1 exactly when the state is not START.
REQ-029 i_en_dec=0 SHALL hold all state, partial field and nibble count; there is no timeout.
REQ-030 i_flush=1 SHALL return to START and clear the partial field and count, with no o_ins_valid pulse; when it coincides with i_en_dec=1, flush SHALL win and the nibble is discarded.
REQ-031 A completion pulse and the next instruction's first nibble MAY occur on consecutive edges; back-to-back decode at one nibble per cycle SHALL be supported.

Reset
REQ-032 While i_reset=0: state START, partial field 0, nibble count 0, o_ins_valid=0, o_ins_class=0, all modifiers 0, o_jump_rel=0, o_jump_field=0, o_busy=0, o_instr_ctr=0.
REQ-033 Reset SHALL take effect immediately without a clock edge and abort any instruction in progress; no pulse SHALL be emitted for it.
REQ-034 Decoding SHALL resume from START on the first i_en_dec edge after reset deasserts.

Verification
REQ-035 Nibbles 0,2 on consecutive cycles -> one pulse: class 1, set_xm=0, set_carry=1, carry_val=1; o_instr_ctr 0->1.
REQ-036 Nibbles 6,3,2,F -> class 6, o_jump_rel=1, o_jump_field=FFF23; nibbles 6,3,2,7 -> o_jump_field=00723.
REQ-037 EN_LONG=1, nibbles 8,D,5,4,3,2,1 -> class 9, o_jump_rel=0, o_jump_field=12345; with EN_LONG=0, nibble 8 -> class F immediately and counter unchanged.
REQ-038 Nibbles 7,1 with i_en_dec low 3 cycles, then 2,3 -> class 7, o_jump_field=00321, o_busy=1 throughout the gap.
REQ-039 Nibbles 8,C,1 then i_flush=1 together with i_en_dec=1 -> no pulse, o_busy=0; next nibbles 0,4 -> class 2.
REQ-040 i_reset low asynchronously after nibble 6 -> o_busy=0 and o_instr_ctr=0 immediately; next nibbles 0,5 -> class 3.

Source files
------------

// File: rtl/saturn_instr_decoder_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | saturn_instr_decoder_if : nibble stream in, decoded instruction out    |
// | Revision 1.0                                                           |
// +-----------------------------------------------------------------------+
interface saturn_instr_decoder_if #(
    parameter int ADDR_NIBBLES = 5
);
    logic                        i_en_dec;
    logic [3:0]                  i_nibble;
    logic                        i_flush;
    logic                        o_ins_valid;
    logic [3:0]                  o_ins_class;
    logic                        o_set_xm;
    logic                        o_set_carry;
    logic                        o_carry_val;
    logic                        o_jump_rel;
    logic [4*ADDR_NIBBLES-1:0]   o_jump_field;
    logic                        o_busy;
    logic [31:0]                 o_instr_ctr;

    modport master (
        output i_en_dec, i_nibble, i_flush,
        input  o_ins_valid, o_ins_class, o_set_xm, o_set_carry, o_carry_val,
               o_jump_rel, o_jump_field, o_busy, o_instr_ctr
    );

    modport slave (
        input  i_en_dec, i_nibble, i_flush,
        output o_ins_valid, o_ins_class, o_set_xm, o_set_carry, o_carry_val,
               o_jump_rel, o_jump_field, o_busy, o_instr_ctr
    );
endinterface
`default_nettype wire

// File: rtl/saturn_instr_decoder.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | saturn_instr_decoder : RTN/SETHEX/SETDEC/GOxx nibble-serial decoder    |
// | Revision 1.0                                                           |
// +-----------------------------------------------------------------------+
module saturn_instr_decoder #(
    parameter int ADDR_NIBBLES = 5,
    parameter bit EN_LONG      = 1'b1
) (
    input  wire logic             i_clk,
    input  wire logic             i_reset,
    saturn_instr_decoder_if.slave bus
);
    localparam int W     = 4 * ADDR_NIBBLES;
    localparam int CNT_W = $clog2(ADDR_NIBBLES + 1);

    localparam logic [1:0] ST_START = 2'd0;
    localparam logic [1:0] ST_B0    = 2'd1;
    localparam logic [1:0] ST_B8    = 2'd2;
    localparam logic [1:0] ST_FIELD = 2'd3;

    localparam logic [3:0] CLS_NONE    = 4'h0;
    localparam logic [3:0] CLS_RTN     = 4'h1;
    localparam logic [3:0] CLS_SETHEX  = 4'h2;
    localparam logic [3:0] CLS_SETDEC  = 4'h3;
    localparam logic [3:0] CLS_GOC     = 4'h4;
    localparam logic [3:0] CLS_GONC    = 4'h5;
    localparam logic [3:0] CLS_GOTO    = 4'h6;
    localparam logic [3:0] CLS_GOSUB   = 4'h7;
    localparam logic [3:0] CLS_GOLONG  = 4'h8;
    localparam logic [3:0] CLS_GOVLNG  = 4'h9;
    localparam logic [3:0] CLS_GOSUBL  = 4'hA;
    localparam logic [3:0] CLS_GOSBVL  = 4'hB;
    localparam logic [3:0] CLS_ILLEGAL = 4'hF;

    localparam logic [CNT_W-1:0] LEN_2    = CNT_W'(2);
    localparam logic [CNT_W-1:0] LEN_3    = CNT_W'(3);
    localparam logic [CNT_W-1:0] LEN_4    = CNT_W'(4);
    localparam logic [CNT_W-1:0] LEN_FULL = CNT_W'(ADDR_NIBBLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Decoder state and partial-field registers
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [3:0]       pcls_q, pcls_d;
    logic [W-1:0]     field_q, field_d;

    // Registered result
    logic             valid_q, valid_d;
    logic [3:0]       cls_q, cls_d;
    logic             xm_q, xm_d;
    logic             sc_q, sc_d;
    logic             cv_q, cv_d;
    logic             rel_q, rel_d;
    logic [W-1:0]     jfield_q, jfield_d;
    logic [31:0]      ctr_q, ctr_d;

    // Completion event from the next-state logic
    logic             w_done;
    logic             w_has_field;
    logic [3:0]       w_cls;
    logic             w_xm;
    logic             w_sc;
    logic             w_cv;

    logic [W-1:0]     w_field_next;
    logic [W-1:0]     w_mask;
    logic [W-1:0]     w_top;
    logic             w_sign;
    logic             w_rel;
    logic [W-1:0]     w_ext;

    // w_mask covers bits above the collected field; w_top isolates its MSB
    assign w_field_next = field_q | ({{(W-4){1'b0}}, bus.i_nibble} << {cnt_q, 2'b00});
    assign w_mask       = {W{1'b1}} << {len_q, 2'b00};
    assign w_top        = ~w_mask & ~(~w_mask >> 1);
    assign w_sign       = |(w_field_next & w_top);
    assign w_rel        = (pcls_q != CLS_GOVLNG) && (pcls_q != CLS_GOSBVL);
    assign w_ext        = (w_rel && w_sign) ? (w_field_next | w_mask) : w_field_next;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q  <= ST_START;
            cnt_q    <= '0;
            len_q    <= '0;
            pcls_q   <= CLS_NONE;
            field_q  <= '0;
            valid_q  <= 1'b0;
            cls_q    <= CLS_NONE;
            xm_q     <= 1'b0;
            sc_q     <= 1'b0;
            cv_q     <= 1'b0;
            rel_q    <= 1'b0;
            jfield_q <= '0;
            ctr_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            pcls_q   <= pcls_d;
            field_q  <= field_d;
            valid_q  <= valid_d;
            cls_q    <= cls_d;
            xm_q     <= xm_d;
            sc_q     <= sc_d;
            cv_q     <= cv_d;
            rel_q    <= rel_d;
            jfield_q <= jfield_d;
            ctr_q    <= ctr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        pcls_d      = pcls_q;
        field_d     = field_q;
        w_done      = 1'b0;
        w_has_field = 1'b0;
        w_cls       = CLS_NONE;
        w_xm        = 1'b0;
        w_sc        = 1'b0;
        w_cv        = 1'b0;

        // Flush outranks a coincident nibble strobe
        if (bus.i_flush) begin
            state_d = ST_START;
            cnt_d   = '0;
            field_d = '0;
        end else if (bus.i_en_dec) begin
            case (state_q)
                ST_START: begin
                    cnt_d   = '0;
                    field_d = '0;
                    case (bus.i_nibble)
                        4'h0: state_d = ST_B0;
                        4'h4, 4'h5: begin
                            state_d = ST_FIELD;
                            len_d   = LEN_2;
                            pcls_d  = bus.i_nibble;
                        end
                        4'h6, 4'h7: begin
                            state_d = ST_FIELD;
                            len_d   = LEN_3;
                            pcls_d  = bus.i_nibble;
                        end
                        4'h8: begin
                            if (EN_LONG) begin
                                state_d = ST_B8;
                            end else begin
                                w_done = 1'b1;
                                w_cls  = CLS_ILLEGAL;
                            end
                        end
                        default: begin
                            w_done = 1'b1;
                            w_cls  = CLS_ILLEGAL;
                        end
                    endcase
                end
                ST_B0: begin
                    state_d = ST_START;
                    w_done  = 1'b1;
                    case (bus.i_nibble)
                        4'h0, 4'h1, 4'h2, 4'h3: begin
                            w_cls = CLS_RTN;
                            w_xm  = (bus.i_nibble == 4'h0);
                            w_sc  = bus.i_nibble[1];
                            w_cv  = (bus.i_nibble == 4'h2);
                        end
                        4'h4:    w_cls = CLS_SETHEX;
                        4'h5:    w_cls = CLS_SETDEC;
                        default: w_cls = CLS_ILLEGAL;
                    endcase
                end
                ST_B8: begin
                    state_d = ST_FIELD;
                    case (bus.i_nibble)
                        4'hC: begin
                            len_d  = LEN_4;
                            pcls_d = CLS_GOLONG;
                        end
                        4'hE: begin
                            len_d  = LEN_4;
                            pcls_d = CLS_GOSUBL;
                        end
                        4'hD: begin
                            len_d  = LEN_FULL;
                            pcls_d = CLS_GOVLNG;
                        end
                        4'hF: begin
                            len_d  = LEN_FULL;
                            pcls_d = CLS_GOSBVL;
                        end
                        default: begin
                            state_d = ST_START;
                            w_done  = 1'b1;
                            w_cls   = CLS_ILLEGAL;
                        end
                    endcase
                end
                default: begin
                    if (cnt_q == len_q - CNT_ONE) begin
                        state_d     = ST_START;
                        cnt_d       = '0;
                        field_d     = '0;
                        w_done      = 1'b1;
                        w_has_field = 1'b1;
                        w_cls       = pcls_q;
                    end else begin
                        cnt_d   = cnt_q + CNT_ONE;
                        field_d = w_field_next;
                    end
                end
            endcase
        end
    end

    always_comb begin
        valid_d  = w_done;
        cls_d    = w_done ? w_cls : CLS_NONE;
        xm_d     = w_done & w_xm;
        sc_d     = w_done & w_sc;
        cv_d     = w_done & w_cv;
        rel_d    = w_done & w_has_field & w_rel;
        jfield_d = (w_done && w_has_field) ? w_ext : jfield_q;
        ctr_d    = (w_done && (w_cls != CLS_ILLEGAL)) ? ctr_q + 32'd1 : ctr_q;
    end

    assign bus.o_ins_valid  = valid_q;
    assign bus.o_ins_class  = cls_q;
    assign bus.o_set_xm     = xm_q;
    assign bus.o_set_carry  = sc_q;
    assign bus.o_carry_val  = cv_q;
    assign bus.o_jump_rel   = rel_q;
    assign bus.o_jump_field = jfield_q;
    assign bus.o_busy       = (state_q != ST_START);
    assign bus.o_instr_ctr  = ctr_q;

endmodule
`default_nettype wire

// File: tb/tb_saturn_instr_decoder.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_saturn_instr_decoder : directed scoreboard bench for the decoder    |
// | Revision 1.0                                                           |
// +-----------------------------------------------------------------------+
module tb_saturn_instr_decoder;
    logic clk;
    logic rst_n;

    saturn_instr_decoder_if #(.ADDR_NIBBLES(5)) bus1 ();
    saturn_instr_decoder_if #(.ADDR_NIBBLES(5)) bus2 ();

    saturn_instr_decoder #(.ADDR_NIBBLES(5), .EN_LONG(1'b1)) u_dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus1)
    );

    saturn_instr_decoder #(.ADDR_NIBBLES(5), .EN_LONG(1'b0)) u_dut_nolong (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  cls;
        logic        xm;
        logic        sc;
        logic        cv;
        logic        rel;
        logic [19:0] field;
        logic [31:0] ctr;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_ctr   = '0;
    logic [19:0] exp_field = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Expected completion; jump classes update the model field, others hold it
    task automatic push(input logic [3:0] cls, input logic xm, input logic sc, input logic cv,
                        input logic rel, input logic is_jump, input logic [19:0] fld);
        exp_t e;
        if (is_jump) exp_field = fld;
        if (cls != 4'hF) exp_ctr = exp_ctr + 32'd1;
        e.cls = cls; e.xm = xm; e.sc = sc; e.cv = cv; e.rel = rel;
        e.field = exp_field; e.ctr = exp_ctr;
        sb.push_back(e);
    endtask

    task automatic cycle_check();
        logic expv;
        exp_t e;
        expv = (sb.size() != 0);
        chk("ins_valid", {31'd0, bus1.o_ins_valid}, {31'd0, expv});
        if (expv) begin
            e = sb.pop_front();
            if (bus1.o_ins_valid) begin
                chk("class",     {28'd0, bus1.o_ins_class}, {28'd0, e.cls});
                chk("set_xm",    {31'd0, bus1.o_set_xm},    {31'd0, e.xm});
                chk("set_carry", {31'd0, bus1.o_set_carry}, {31'd0, e.sc});
                chk("carry_val", {31'd0, bus1.o_carry_val}, {31'd0, e.cv});
                chk("jump_rel",  {31'd0, bus1.o_jump_rel},  {31'd0, e.rel});
                chk("jump_field", {12'd0, bus1.o_jump_field}, {12'd0, e.field});
                chk("instr_ctr", bus1.o_instr_ctr, e.ctr);
            end
        end else if (!bus1.o_ins_valid) begin
            chk("idle_class", {28'd0, bus1.o_ins_class},
                {28'd0, 4'h0});
            chk("idle_mods", {29'd0, bus1.o_set_xm, bus1.o_set_carry, bus1.o_jump_rel}, 32'd0);
            chk("idle_field", {12'd0, bus1.o_jump_field}, {12'd0, exp_field});
            chk("idle_ctr", bus1.o_instr_ctr, exp_ctr);
        end
    endtask

    task automatic nib(input logic [3:0] n);
        bus1.i_en_dec = 1'b1;
        bus1.i_nibble = n;
        @(negedge clk);
        bus1.i_en_dec = 1'b0;
        cycle_check();
    endtask

    task automatic idle();
        @(negedge clk);
        cycle_check();
    endtask

    task automatic nib2(input logic [3:0] n);
        bus2.i_en_dec = 1'b1;
        bus2.i_nibble = n;
        @(negedge clk);
        bus2.i_en_dec = 1'b0;
        cycle_check();
    endtask

    initial begin
        bus1.i_en_dec = 1'b0; bus1.i_nibble = 4'h0; bus1.i_flush = 1'b0;
        bus2.i_en_dec = 1'b0; bus2.i_nibble = 4'h0; bus2.i_flush = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", {31'd0, bus1.o_ins_valid}, 32'd0);
        chk("rst_class", {28'd0, bus1.o_ins_class}, 32'd0);
        chk("rst_busy",  {31'd0, bus1.o_busy}, 32'd0);
        chk("rst_field", {12'd0, bus1.o_jump_field}, 32'd0);
        chk("rst_ctr",   bus1.o_instr_ctr, 32'd0);
        rst_n = 1'b1;
        idle();

        // RTN with carry set: 0,2
        nib(4'h0);
        chk("busy_b0", {31'd0, bus1.o_busy}, 32'd1);
        push(4'h1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 20'h0);
        nib(4'h2);
        chk("busy_after_rtn", {31'd0, bus1.o_busy}, 32'd0);

        // GOTO negative and positive offsets
        nib(4'h6); nib(4'h3); nib(4'h2);
        push(4'h6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 20'hFFF23);
        nib(4'hF);
        nib(4'h6); nib(4'h3); nib(4'h2);
        push(4'h6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 20'h00723);
        nib(4'h7);

        // GOVLNG absolute, full width
        nib(4'h8); nib(4'hD); nib(4'h5); nib(4'h4); nib(4'h3); nib(4'h2);
        push(4'h9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 20'h12345);
        nib(4'h1);

        // GOSUB with a strobe gap
        nib(4'h7); nib(4'h1);
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("busy_gap", {31'd0, bus1.o_busy}, 32'd1);
        end
        nib(4'h2);
        push(4'h7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 20'h00321);
        nib(4'h3);

        // Flush together with a strobe discards the nibble
        nib(4'h8); nib(4'hC); nib(4'h1);
        bus1.i_flush = 1'b1;
        nib(4'h2);
        bus1.i_flush = 1'b0;
        chk("busy_flush", {31'd0, bus1.o_busy}, 32'd0);
        nib(4'h0);
        push(4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 20'h0);
        nib(4'h4);

        // Illegal first nibble and illegal B0 follow-up
        push(4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 20'h0);
        nib(4'h9);
        nib(4'h0);
        push(4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 20'h0);
        nib(4'h7);

        // Short relatives, long relative, long absolute
        nib(4'h4); nib(4'hF);
        push(4'h4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 20'hFFFFF);
        nib(4'hF);
        nib(4'h5); nib(4'h0);
        push(4'h5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 20'h00070);
        nib(4'h7);
        nib(4'h8); nib(4'hE); nib(4'h1); nib(4'h2); nib(4'h3);
        push(4'hA, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 20'hF8321);
        nib(4'h8);
        nib(4'h8); nib(4'hF); nib(4'h0); nib(4'h0); nib(4'h0); nib(4'h0);
        push(4'hB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 20'h90000);
        nib(4'h9);
        nib(4'h8);
        push(4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 20'h0);
        nib(4'h3);

        // Remaining RTN flavours, back to back
        nib(4'h0);
        push(4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 20'h0);
        nib(4'h0);
        nib(4'h0);
        push(4'h1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 20'h0);
        nib(4'h3);
        nib(4'h0);
        push(4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 20'h0);
        nib(4'h1);

        // EN_LONG=0 instance: 8 is illegal at once
        nib2(4'h8);
        chk("nl_valid", {31'd0, bus2.o_ins_valid}, 32'd1);
        chk("nl_class", {28'd0, bus2.o_ins_class}, 32'hF);
        chk("nl_ctr",   bus2.o_instr_ctr, 32'd0);
        chk("nl_busy",  {31'd0, bus2.o_busy}, 32'd0);
        nib2(4'h0);
        nib2(4'h4);
        chk("nl_sethex", {28'd0, bus2.o_ins_class}, 32'h2);
        chk("nl_ctr2",   bus2.o_instr_ctr, 32'd1);

        // Asynchronous reset mid-instruction
        nib(4'h6);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy",  {31'd0, bus1.o_busy}, 32'd0);
        chk("arst_ctr",   bus1.o_instr_ctr, 32'd0);
        chk("arst_valid", {31'd0, bus1.o_ins_valid}, 32'd0);
        chk("arst_field", {12'd0, bus1.o_jump_field}, 32'd0);
        exp_ctr = '0;
        exp_field = '0;
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        nib(4'h0);
        push(4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 20'h0);
        nib(4'h5);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
